vx_perf_ctr_bank: RTL and testbench
===================================

VX_PERF_CTR_BANK -- requirements
Module: VX_perf_ctr_bank

Interface
REQ-001 SHALL have parameter NUM_CTRS, default 15, number of independent event counters.
REQ-002 SHALL have parameter CTR_W, default 44, counter width (equals PERF_CTR_BITS).
REQ-003 SHALL have parameter INC_W, default 4, width of each per-cycle increment.
REQ-004 SHALL have parameter SATURATE, default 0; 0 = wrap modulo 2^CTR_W, 1 = clamp at all-ones.
REQ-005 SHALL have port clk, input, 1, sole clock; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, global count enable.
REQ-008 SHALL have port clear, input, 1, one-cycle pulse zeroing all live counters and overflow flags.
REQ-009 SHALL have port inc, input, NUM_CTRS*INC_W, per-counter increment; counter i uses bits [i*INC_W +: INC_W].
REQ-010 SHALL have ports snap_valid (input, 1) and snap_ready (output, 1), snapshot request handshake.
REQ-011 SHALL have ports rd_req_valid (input, 1), rd_req_addr (input, clog2(NUM_CTRS), min 1), rd_req_ready (output, 1).
REQ-012 SHALL have ports rd_rsp_valid (output, 1), rd_rsp_data (output, CTR_W), rd_rsp_ready (input, 1).
REQ-013 SHALL have port ovf, output, NUM_CTRS, sticky per-counter overflow flags.

Function
REQ-014 Each cycle with enable=1 and clear=0, live[i] SHALL become live[i] + inc[i] (inc zero-extended to CTR_W).
REQ-015 With SATURATE=0, a sum exceeding 2^CTR_W-1 SHALL wrap modulo 2^CTR_W and set ovf[i].
REQ-016 With SATURATE=1, a sum exceeding 2^CTR_W-1 SHALL produce all-ones and set ovf[i]; a counter at all-ones SHALL stay there.
REQ-017 With enable=0, live counters SHALL hold, except that clear still applies.
REQ-018 clear SHALL take priority over inc in the same cycle: live and ovf become 0 that cycle, and that cycle's increments are discarded.
REQ-019 clear SHALL NOT alter the shadow registers or an in-flight read response.
REQ-020 A snapshot fires on snap_valid & snap_ready; shadow[i] SHALL load the registered live[i] value from before that cycle's update.
REQ-021 The read FSM SHALL have states IDLE and RSP.
REQ-022 In IDLE, rd_req_ready SHALL be 1; on rd_req_valid the FSM SHALL go to RSP and register shadow[rd_req_addr].
REQ-023 In RSP, rd_rsp_valid SHALL be 1 and rd_rsp_data SHALL stay stable until rd_rsp_ready; on rd_rsp_ready the FSM SHALL return to IDLE.
REQ-024 Response latency SHALL be exactly 1 cycle, back-to-back throughput 1 read per 2 cycles, with no bypass.
REQ-025 rd_req_ready SHALL be 0 in RSP.
REQ-026 snap_ready SHALL equal (state==IDLE) & ~rd_req_valid, so a read request wins over a snapshot in the same cycle.
REQ-027 rd_req_addr >= NUM_CTRS SHALL return rd_rsp_data = 0 with the normal handshake.

Reset
REQ-028 Asynchronous reset SHALL zero all live counters, shadow registers, ovf, and rd_rsp_data, and force the FSM to IDLE.
REQ-029 Reset asserted mid-response SHALL drop rd_rsp_valid immediately; no response is replayed afterwards.
REQ-030 Reset values: rd_req_ready=1, snap_ready=1, rd_rsp_valid=0.

Structure
REQ-031 VX_perf_pkg SHALL hold the read-FSM state enum and the default CTR_W/INC_W localparams.
REQ-032 Per-counter accumulate, saturate/wrap and ovf logic SHALL be the sub-module VX_perf_ctr, instantiated NUM_CTRS times by generate.
REQ-033 Shadow registers and the read FSM SHALL reside in VX_perf_ctr_bank.

Verification
REQ-034 Set enable=1 and inc[2]=3 for 10 cycles, then snapshot and read addr 2 -> rd_rsp_data=30, ovf[2]=0.
REQ-035 With CTR_W=8, SATURATE=0: preload to 250, then inc=10 -> live=4, ovf=1; with SATURATE=1 the same stimulus -> live=255, ovf=1.
REQ-036 Assert clear and inc[0]=5 in the same cycle with live[0]=7 -> live[0]=0, ovf=0; shadow[0] is unchanged.
REQ-037 Read addr 1 and hold rd_rsp_ready=0 for 5 cycles -> data stable, rd_req_ready=0, snap_ready=0; snap_valid is ignored until the handshake completes.
REQ-038 Read addr NUM_CTRS+1 -> rsp at +1 cycle with data 0; assert reset during RSP -> rd_rsp_valid=0 in the same cycle, and all reads after reset return 0.

Source files
------------

// File: rtl/vx_perf_ctr_bank_pkg.sv
// Shared definitions for the performance counter bank:
// default counter/increment widths, the read FSM state type
// and the address width helper used for the read port.
package vx_perf_pkg;

  localparam int PERF_CTR_BITS = 44;
  localparam int PERF_INC_BITS = 4;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RSP  = 1'b1
  } rd_state_e;

  // Address width for a bank of n counters, never narrower than one bit.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_perf_ctr_bank_ctr.sv
// Single event counter: accumulates a small per-cycle increment,
// either wrapping or clamping at all-ones, with a sticky overflow flag.
module vx_perf_ctr
  import vx_perf_pkg::*;
#(
  parameter int CTR_W    = PERF_CTR_BITS,
  parameter int INC_W    = PERF_INC_BITS,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [INC_W-1:0] inc,
  output logic [CTR_W-1:0] count,
  output logic             ovf
);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [CTR_W:0]   sum;

  // Next count: clear wins, otherwise add with carry detection when enabled.
  always_comb begin
    sum     = {1'b0, count_q} + {{(CTR_W + 1 - INC_W){1'b0}}, inc};
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (enable) begin
      if (sum[CTR_W]) begin
        ovf_d   = 1'b1;
        count_d = (SATURATE != 0) ? {CTR_W{1'b1}} : sum[CTR_W-1:0];
      end else begin
        count_d = sum[CTR_W-1:0];
      end
    end
  end

  // Counter and overflow flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/vx_perf_ctr_bank.sv
// Bank of independent event counters with a snapshot shadow copy
// and a one-outstanding-read request/response port onto the shadows.
module vx_perf_ctr_bank
  import vx_perf_pkg::*;
#(
  parameter int NUM_CTRS = 15,
  parameter int CTR_W    = PERF_CTR_BITS,
  parameter int INC_W    = PERF_INC_BITS,
  parameter int SATURATE = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            clear,
  input  logic [NUM_CTRS*INC_W-1:0]       inc,
  input  logic                            snap_valid,
  output logic                            snap_ready,
  input  logic                            rd_req_valid,
  input  logic [addr_bits(NUM_CTRS)-1:0]  rd_req_addr,
  output logic                            rd_req_ready,
  output logic                            rd_rsp_valid,
  output logic [CTR_W-1:0]                rd_rsp_data,
  input  logic                            rd_rsp_ready,
  output logic [NUM_CTRS-1:0]             ovf
);

  localparam int ADDR_W = addr_bits(NUM_CTRS);

  logic [CTR_W-1:0] live     [NUM_CTRS];
  logic [CTR_W-1:0] shadow_q [NUM_CTRS];
  logic [CTR_W-1:0] shadow_d [NUM_CTRS];
  logic [CTR_W-1:0] rsp_data_q;
  logic [CTR_W-1:0] rsp_data_d;
  logic [CTR_W-1:0] rd_sel;
  logic             snap_fire;
  rd_state_e        state_q;
  rd_state_e        state_d;

  for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
    vx_perf_ctr #(
      .CTR_W    (CTR_W),
      .INC_W    (INC_W),
      .SATURATE (SATURATE)
    ) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (clear),
      .inc    (inc[g*INC_W +: INC_W]),
      .count  (live[g]),
      .ovf    (ovf[g])
    );
  end

  // Shadow read mux; out-of-range addresses match nothing and read as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (rd_req_addr == ADDR_W'(i)) begin
        rd_sel = shadow_q[i];
      end
    end
  end

  // Read FSM next state, handshake outputs and response data capture.
  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    snap_ready   = 1'b0;
    case (state_q)
      RD_IDLE: begin
        rd_req_ready = 1'b1;
        snap_ready   = ~rd_req_valid;
        if (rd_req_valid) begin
          state_d    = RD_RSP;
          rsp_data_d = rd_sel;
        end
      end
      RD_RSP: begin
        rd_rsp_valid = 1'b1;
        if (rd_rsp_ready) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Snapshot copies the registered live values, i.e. before this cycle's update.
  always_comb begin
    snap_fire = snap_valid & snap_ready;
    for (int i = 0; i < NUM_CTRS; i++) begin
      shadow_d[i] = snap_fire ? live[i] : shadow_q[i];
    end
  end

  // Read FSM state and held response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RD_IDLE;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Shadow registers; clear deliberately does not touch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign rd_rsp_data = rsp_data_q;

endmodule

// File: tb/tb_vx_perf_ctr_bank.sv
// Bench for vx_perf_ctr_bank: one default-parameter bank plus two 8-bit
// banks (wrapping and saturating) driven by the same stimulus, checked
// against a behavioural model every cycle and by literal expectations.
module tb_vx_perf_ctr_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [59:0] inc;
  logic        snap_valid;
  logic        rd_req_valid;
  logic [3:0]  rd_req_addr;
  logic        rd_rsp_ready;

  logic        snap_ready_m, rd_req_ready_m, rd_rsp_valid_m;
  logic [43:0] rd_rsp_data_m;
  logic [14:0] ovf_m;
  logic        snap_ready_w, rd_req_ready_w, rd_rsp_valid_w;
  logic [7:0]  rd_rsp_data_w;
  logic [5:0]  ovf_w;
  logic        snap_ready_s, rd_req_ready_s, rd_rsp_valid_s;
  logic [7:0]  rd_rsp_data_s;
  logic [5:0]  ovf_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vx_perf_ctr_bank dut_m (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inc(inc),
    .snap_valid(snap_valid), .snap_ready(snap_ready_m),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready_m),
    .rd_rsp_valid(rd_rsp_valid_m), .rd_rsp_data(rd_rsp_data_m), .rd_rsp_ready(rd_rsp_ready),
    .ovf(ovf_m)
  );

  vx_perf_ctr_bank #(.NUM_CTRS(6), .CTR_W(8), .INC_W(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inc(inc[23:0]),
    .snap_valid(snap_valid), .snap_ready(snap_ready_w),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr[2:0]), .rd_req_ready(rd_req_ready_w),
    .rd_rsp_valid(rd_rsp_valid_w), .rd_rsp_data(rd_rsp_data_w), .rd_rsp_ready(rd_rsp_ready),
    .ovf(ovf_w)
  );

  vx_perf_ctr_bank #(.NUM_CTRS(6), .CTR_W(8), .INC_W(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inc(inc[23:0]),
    .snap_valid(snap_valid), .snap_ready(snap_ready_s),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr[2:0]), .rd_req_ready(rd_req_ready_s),
    .rd_rsp_valid(rd_rsp_valid_s), .rd_rsp_data(rd_rsp_data_s), .rd_rsp_ready(rd_rsp_ready),
    .ovf(ovf_s)
  );

  // Uniform views of the three banks' outputs, indexed 0=main, 1=wrap, 2=sat.
  logic [14:0] d_ovf  [3];
  logic [63:0] d_data [3];
  logic        d_rqr  [3];
  logic        d_snr  [3];
  logic        d_rv   [3];

  assign d_ovf[0]  = ovf_m;
  assign d_ovf[1]  = 15'(ovf_w);
  assign d_ovf[2]  = 15'(ovf_s);
  assign d_data[0] = 64'(rd_rsp_data_m);
  assign d_data[1] = 64'(rd_rsp_data_w);
  assign d_data[2] = 64'(rd_rsp_data_s);
  assign d_rqr[0]  = rd_req_ready_m;
  assign d_rqr[1]  = rd_req_ready_w;
  assign d_rqr[2]  = rd_req_ready_s;
  assign d_snr[0]  = snap_ready_m;
  assign d_snr[1]  = snap_ready_w;
  assign d_snr[2]  = snap_ready_s;
  assign d_rv[0]   = rd_rsp_valid_m;
  assign d_rv[1]   = rd_rsp_valid_w;
  assign d_rv[2]   = rd_rsp_valid_s;

  function automatic int cfg_w(input int k);
    return (k == 0) ? 44 : 8;
  endfunction

  function automatic int cfg_n(input int k);
    return (k == 0) ? 15 : 6;
  endfunction

  function automatic int cfg_aw(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic longint unsigned maxv(input int k);
    return (64'd1 << cfg_w(k)) - 64'd1;
  endfunction

  // Counter arithmetic from the rules: wrap modulo 2^W, or clamp for bank 2.
  function automatic longint unsigned add_live(input int k, input longint unsigned cur,
                                               input longint unsigned d);
    longint unsigned s;
    s = cur + d;
    if (s <= maxv(k)) return s;
    if (k == 2) return maxv(k);
    return s - (maxv(k) + 64'd1);
  endfunction

  function automatic bit add_ovf(input int k, input longint unsigned cur,
                                 input longint unsigned d);
    return (cur + d) > maxv(k);
  endfunction

  // Behavioural model state.
  longint unsigned m_live   [3][15];
  longint unsigned m_shadow [3][15];
  bit              m_ovf    [3][15];
  longint unsigned m_data   [3];
  bit              m_pend;

  function automatic longint unsigned lookup(input int k, input logic [3:0] addr);
    int a;
    a = int'(addr) & ((1 << cfg_aw(k)) - 1);
    if (a < cfg_n(k)) return m_shadow[k][a];
    return 64'd0;
  endfunction

  // Model update: one outstanding read, snapshot only when idle and no request.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_data[k] <= 64'd0;
        for (int i = 0; i < 15; i++) begin
          m_live[k][i]   <= 64'd0;
          m_shadow[k][i] <= 64'd0;
          m_ovf[k][i]    <= 1'b0;
        end
      end
    end else begin
      if (!m_pend) begin
        if (rd_req_valid) begin
          m_pend <= 1'b1;
          for (int k = 0; k < 3; k++) m_data[k] <= lookup(k, rd_req_addr);
        end
      end else if (rd_rsp_ready) begin
        m_pend <= 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < cfg_n(k); i++) begin
          if (!m_pend && !rd_req_valid && snap_valid) m_shadow[k][i] <= m_live[k][i];
          if (clear) begin
            m_live[k][i] <= 64'd0;
            m_ovf[k][i]  <= 1'b0;
          end else if (enable) begin
            m_live[k][i] <= add_live(k, m_live[k][i], 64'(inc[i*4 +: 4]));
            if (add_ovf(k, m_live[k][i], 64'(inc[i*4 +: 4]))) m_ovf[k][i] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput();
    logic [14:0] e_ovf;
    for (int k = 0; k < 3; k++) begin
      e_ovf = '0;
      for (int i = 0; i < cfg_n(k); i++) e_ovf[i] = m_ovf[k][i];
      compareValue($sformatf("dut%0d ovf", k), 64'(d_ovf[k]), 64'(e_ovf));
      compareValue($sformatf("dut%0d rd_req_ready", k), 64'(d_rqr[k]), 64'(!m_pend));
      compareValue($sformatf("dut%0d snap_ready", k), 64'(d_snr[k]), 64'(!m_pend && !rd_req_valid));
      compareValue($sformatf("dut%0d rd_rsp_valid", k), 64'(d_rv[k]), 64'(m_pend));
      if (m_pend) compareValue($sformatf("dut%0d rd_rsp_data", k), d_data[k], m_data[k]);
    end
  endtask

  // Model comparison on the inactive clock edge.
  always @(negedge clk) begin
    if (!reset) checkOutput();
  end

  function automatic logic [59:0] mk_inc(input int idx, input int val);
    logic [59:0] v;
    v = '0;
    v[idx*4 +: 4] = 4'(val);
    return v;
  endfunction

  task automatic applyStimulus(input bit en, input bit clr, input logic [59:0] iv,
                               input bit sv, input bit rv, input logic [3:0] a, input bit rr);
    enable       = en;
    clear        = clr;
    inc          = iv;
    snap_valid   = sv;
    rd_req_valid = rv;
    rd_req_addr  = a;
    rd_rsp_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  // Read with exactly one cycle of latency, then complete the handshake.
  task automatic expect_read(input logic [3:0] a, input longint unsigned e0,
                             input longint unsigned e1, input longint unsigned e2);
    longint unsigned e [3];
    e = '{e0, e1, e2};
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, a, 1'b0);
    for (int k = 0; k < 3; k++) begin
      compareValue($sformatf("read%0d dut%0d rsp latency", a, k), 64'(d_rv[k]), 64'd1);
      compareValue($sformatf("read%0d dut%0d data", a, k), d_data[k], e[k]);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, a, 1'b1);
    compareValue($sformatf("read%0d rsp done", a), 64'(d_rv[0]), 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    clear        = 1'b0;
    inc          = '0;
    snap_valid   = 1'b0;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    rd_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      compareValue($sformatf("reset dut%0d rd_req_ready", k), 64'(d_rqr[k]), 64'd1);
      compareValue($sformatf("reset dut%0d snap_ready", k), 64'(d_snr[k]), 64'd1);
      compareValue($sformatf("reset dut%0d rd_rsp_valid", k), 64'(d_rv[k]), 64'd0);
      compareValue($sformatf("reset dut%0d ovf", k), 64'(d_ovf[k]), 64'd0);
      compareValue($sformatf("reset dut%0d rd_rsp_data", k), d_data[k], 64'd0);
    end
    reset = 1'b0;

    // Ten cycles of inc[2]=3 (and inc[7]=1 on the wide bank).
    repeat (10) applyStimulus(1'b1, 1'b0, mk_inc(2, 3) | mk_inc(7, 1), 1'b0, 1'b0, 4'd0, 1'b0);
    snapshot();
    compareValue("ovf[2] after accumulate", 64'(d_ovf[0][2]), 64'd0);
    expect_read(4'd2, 30, 30, 30);
    expect_read(4'd7, 10, 0, 0);
    expect_read(4'd15, 0, 0, 0);

    // Preload counter 3 to 250, then add 10 to cross 255 on the 8-bit banks.
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (16) applyStimulus(1'b1, 1'b0, mk_inc(3, 15), 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, mk_inc(3, 10), 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, mk_inc(3, 10), 1'b0, 1'b0, 4'd0, 1'b0);
    compareValue("ovf[3] main", 64'(d_ovf[0][3]), 64'd0);
    compareValue("ovf[3] wrap", 64'(d_ovf[1][3]), 64'd1);
    compareValue("ovf[3] sat", 64'(d_ovf[2][3]), 64'd1);
    snapshot();
    expect_read(4'd3, 260, 4, 255);
    applyStimulus(1'b1, 1'b0, mk_inc(3, 15), 1'b0, 1'b0, 4'd0, 1'b0);
    snapshot();
    expect_read(4'd3, 275, 19, 255);

    // Clear collides with an increment; shadow keeps its old snapshot.
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, mk_inc(0, 7), 1'b0, 1'b0, 4'd0, 1'b0);
    snapshot();
    applyStimulus(1'b1, 1'b1, mk_inc(0, 5), 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++)
      compareValue($sformatf("clear dut%0d ovf", k), 64'(d_ovf[k]), 64'd0);
    expect_read(4'd0, 7, 7, 7);
    snapshot();
    expect_read(4'd0, 0, 0, 0);

    // Stalled response: data holds, snapshots and clear are ignored by it.
    repeat (3) applyStimulus(1'b1, 1'b0, mk_inc(1, 2), 1'b0, 1'b0, 4'd0, 1'b0);
    snapshot();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd1, 1'b0);
    for (int h = 0; h < 5; h++) begin
      applyStimulus(1'b1, (h == 2), mk_inc(1, 1), 1'b1, 1'b0, 4'd1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        compareValue($sformatf("hold%0d dut%0d rd_rsp_valid", h, k), 64'(d_rv[k]), 64'd1);
        compareValue($sformatf("hold%0d dut%0d data", h, k), d_data[k], 64'd6);
        compareValue($sformatf("hold%0d dut%0d rd_req_ready", h, k), 64'(d_rqr[k]), 64'd0);
        compareValue($sformatf("hold%0d dut%0d snap_ready", h, k), 64'(d_snr[k]), 64'd0);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'd1, 1'b1);
    expect_read(4'd1, 6, 6, 6);
    snapshot();
    expect_read(4'd1, 2, 2, 2);

    // Reset while a response is outstanding.
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd1, 1'b0);
    compareValue("pre-reset rd_rsp_valid", 64'(d_rv[0]), 64'd1);
    rd_req_valid = 1'b0;
    reset        = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      compareValue($sformatf("mid-rsp reset dut%0d rd_rsp_valid", k), 64'(d_rv[k]), 64'd0);
      compareValue($sformatf("mid-rsp reset dut%0d rd_req_ready", k), 64'(d_rqr[k]), 64'd1);
      compareValue($sformatf("mid-rsp reset dut%0d snap_ready", k), 64'(d_snr[k]), 64'd1);
      compareValue($sformatf("mid-rsp reset dut%0d data", k), d_data[k], 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0);
    expect_read(4'd1, 0, 0, 0);
    expect_read(4'd2, 0, 0, 0);
    expect_read(4'd3, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
